// File: rtl/stamp_reader_pkg.sv
// Shared definitions for the timestamp writer/reader pair: AXI constants,
// the sequencing state encoding and the 4 KB-safe burst length helper.
package profcounter_pkg;

  localparam logic [2:0] AXI_SIZE_8B = 3'd3;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam int         BOUNDARY_4K = 4096;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_BEATS,
    ST_DRAIN
  } state_t;

  // Beats for the next burst: limited by words left, the burst cap and the
  // distance to the next 4 KB page (address is always 8-byte aligned).
  function automatic logic [9:0] burst_len(input logic [11:0] addr_lo,
                                           input logic [31:0] remaining,
                                           input int          max_burst);
    logic [9:0] to_4k;
    logic [9:0] len;
    to_4k = 10'((13'(BOUNDARY_4K) - {1'b0, addr_lo}) >> 3);
    len   = 10'(max_burst);
    if (to_4k < len) len = to_4k;
    if (remaining < {22'd0, len}) len = remaining[9:0];
    return len;
  endfunction

endpackage

// File: rtl/stamp_reader_if.sv
// AXI4 read channels of the gmem master plus the AXI4-Stream source pipe
// of the timestamp reader.
interface stamp_reader_if;
  logic        axiARVALID;
  logic        axiARREADY;
  logic [63:0] axiARADDR;
  logic [7:0]  axiARLEN;
  logic [2:0]  axiARSIZE;
  logic        axiRVALID;
  logic        axiRREADY;
  logic [63:0] axiRDATA;
  logic        axiRLAST;
  logic [1:0]  axiRRESP;
  logic [63:0] pipeTDATA;
  logic        pipeTVALID;
  logic        pipeTREADY;
  logic        pipeTLAST;

  modport master (
    output axiARVALID, axiARADDR, axiARLEN, axiARSIZE, axiRREADY,
           pipeTDATA, pipeTVALID, pipeTLAST,
    input  axiARREADY, axiRVALID, axiRDATA, axiRLAST, axiRRESP, pipeTREADY
  );

  modport slave (
    input  axiARVALID, axiARADDR, axiARLEN, axiARSIZE, axiRREADY,
           pipeTDATA, pipeTVALID, pipeTLAST,
    output axiARREADY, axiRVALID, axiRDATA, axiRLAST, axiRRESP, pipeTREADY
  );
endinterface

// File: rtl/stamp_reader_sync_fifo.sv
// Single-clock FIFO with the head word read straight from storage registers
// and a free-entry count for credit-based request throttling.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     free
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [FW-1:0]    used;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign empty = (used == '0);
  assign full  = (used == FW'(DEPTH));
  assign free  = FW'(DEPTH) - used;
  assign dout  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   used <= used + 1'b1;
        2'b01:   used <= used - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/stamp_reader.sv
// Streams stored 64-bit timestamps from global memory to an AXI4-Stream pipe,
// one AR burst outstanding at a time, bursts clipped at 4 KB pages.
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_REQ   | issuing the next AR burst once the FIFO has room for it
// ST_BEATS | accepting R beats of the outstanding burst
// ST_DRAIN | all bursts fetched, waiting for the last stream word to leave
module stamp_reader
  import profcounter_pkg::*;
#(
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  start,
  input  logic [63:0]           offset,
  input  logic [31:0]           count,
  output logic                  idle,
  output logic                  done,
  output logic                  error,
  stamp_reader_if.master        bus
);
  localparam int FW = $clog2(FIFO_DEPTH) + 1;

  state_t        state;
  logic [63:0]   addr;
  logic [31:0]   remaining;
  logic [31:0]   out_left;
  logic [9:0]    cur_len;
  logic          ar_valid;
  logic [63:0]   ar_addr;
  logic [7:0]    ar_len;
  logic          rready;
  logic          r_hs;
  logic          t_hs;
  logic [9:0]    next_len;
  logic [9:0]    start_len;
  logic          fifo_empty;
  logic          fifo_full;
  logic [FW-1:0] fifo_free;
  logic [63:0]   head;

  assign next_len  = burst_len(addr[11:0], remaining, MAX_BURST);
  assign start_len = burst_len(offset[11:0], count, MAX_BURST);
  assign rready    = (state == ST_BEATS) && !fifo_full;
  assign r_hs      = bus.axiRVALID && rready;
  assign t_hs      = !fifo_empty && bus.pipeTREADY;
  assign idle      = (state == ST_IDLE);

  assign bus.axiARVALID = ar_valid;
  assign bus.axiARADDR  = ar_addr;
  assign bus.axiARLEN   = ar_len;
  assign bus.axiARSIZE  = AXI_SIZE_8B;
  assign bus.axiRREADY  = rready;
  assign bus.pipeTVALID = !fifo_empty;
  assign bus.pipeTDATA  = head;
  assign bus.pipeTLAST  = !fifo_empty && (out_left == 32'd1);

  sync_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .push  (r_hs),
    .din   (bus.axiRDATA),
    .pop   (bus.pipeTREADY),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .free  (fifo_free)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= ST_IDLE;
      addr      <= '0;
      remaining <= '0;
      out_left  <= '0;
      cur_len   <= '0;
      ar_valid  <= 1'b0;
      ar_addr   <= '0;
      ar_len    <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (t_hs) out_left <= out_left - 32'd1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr      <= offset;
            remaining <= count;
            out_left  <= count;
            error     <= 1'b0;
            if (count == '0) begin
              state <= ST_DRAIN;
            end else begin
              // FIFO is empty here, so the first request needs no credit check.
              state    <= ST_REQ;
              ar_valid <= 1'b1;
              ar_addr  <= offset;
              ar_len   <= 8'(start_len - 10'd1);
              cur_len  <= start_len;
            end
          end
        end
        ST_REQ: begin
          if (ar_valid) begin
            if (bus.axiARREADY) begin
              ar_valid <= 1'b0;
              state    <= ST_BEATS;
            end
          end else if ({{(32-FW){1'b0}}, fifo_free} >= {22'd0, next_len}) begin
            ar_valid <= 1'b1;
            ar_addr  <= addr;
            ar_len   <= 8'(next_len - 10'd1);
            cur_len  <= next_len;
          end
        end
        ST_BEATS: begin
          if (r_hs) begin
            if (bus.axiRRESP != RESP_OKAY) error <= 1'b1;
            if (bus.axiRLAST) begin
              addr      <= addr + {51'd0, cur_len, 3'd0};
              remaining <= remaining - {22'd0, cur_len};
              state     <= (remaining == {22'd0, cur_len}) ? ST_DRAIN : ST_REQ;
            end
          end
        end
        ST_DRAIN: begin
          if (out_left == '0 || (t_hs && out_left == 32'd1)) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
